// File: rtl/four_digit_seven_segment_decoder_pkg.sv
// Shared constants for the four-digit seven-segment driver.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] ANODES_OFF = 4'hF;

    // One-hot-low anode select for digit k.
    function automatic logic [3:0] anode_sel(input logic [1:0] k);
        anode_sel = ~(4'b0001 << k);
    endfunction

endpackage

// File: rtl/four_digit_seven_segment_decoder_if.sv
// Display bundle: digit values, enable mask and mode in; anodes/cathodes out.
// master drives the digit data, slave is the display driver.
interface four_digit_seven_segment_decoder_if;

    logic [3:0] v3;
    logic [3:0] v2;
    logic [3:0] v1;
    logic [3:0] v0;
    logic [3:0] digits;
    logic       decimal;
    logic [3:0] anodes;
    logic [7:0] cathodes;

    modport master (
        output v3, v2, v1, v0, digits, decimal,
        input  anodes, cathodes
    );

    modport slave (
        input  v3, v2, v1, v0, digits, decimal,
        output anodes, cathodes
    );

endinterface

// File: rtl/four_digit_seven_segment_decoder_seg7_decoder.sv
// Combinational 4-bit value to active-low segment pattern.
// Ports: value (digit), decimal (1 blanks 10..15), cathodes (pattern, dp off).
module seg7_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       decimal,
    output logic [7:0] cathodes
);

    logic [7:0] pat;

    always_comb begin
        pat = SEG_BLANK;
        unique case (value)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = decimal ? SEG_BLANK : SEG_A;
            4'hB: pat = decimal ? SEG_BLANK : SEG_B;
            4'hC: pat = decimal ? SEG_BLANK : SEG_C;
            4'hD: pat = decimal ? SEG_BLANK : SEG_D;
            4'hE: pat = decimal ? SEG_BLANK : SEG_E;
            4'hF: pat = decimal ? SEG_BLANK : SEG_F;
        endcase
    end

    // The decimal point is never lit.
    assign cathodes = {1'b1, pat[6:0]};

endmodule

// File: rtl/four_digit_seven_segment_decoder.sv
// Time-multiplexed four-digit common-anode seven-segment driver.
// Ports: clk_100MHz, rst_n (async low), bus (slave: digits in, anodes/cathodes out).
module four_digit_seven_segment_decoder
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_BITS = 20
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    four_digit_seven_segment_decoder_if.slave bus
);

    logic [REFRESH_BITS-1:0] cnt_q;
    logic [REFRESH_BITS-1:0] cnt_d;
    logic [1:0]              slot;
    logic [3:0]              val;
    logic                    en;
    logic [7:0]              seg;
    logic [3:0]              anodes_q;
    logic [3:0]              anodes_d;
    logic [7:0]              cathodes_q;
    logic [7:0]              cathodes_d;

    // Top two counter bits pick the digit slot.
    assign slot  = cnt_q[REFRESH_BITS-1 -: 2];
    assign cnt_d = cnt_q + 1'b1;

    always_comb begin
        val = bus.v0;
        en  = bus.digits[0];
        unique case (slot)
            2'd0: begin val = bus.v0; en = bus.digits[0]; end
            2'd1: begin val = bus.v1; en = bus.digits[1]; end
            2'd2: begin val = bus.v2; en = bus.digits[2]; end
            2'd3: begin val = bus.v3; en = bus.digits[3]; end
        endcase
    end

    seg7_decoder u_dec (
        .value    (val),
        .decimal  (bus.decimal),
        .cathodes (seg)
    );

    // Anode and segments are chosen from the same slot in the same cycle,
    // so a slot change can never overlap two low anodes.
    assign anodes_d   = en ? anode_sel(slot) : ANODES_OFF;
    assign cathodes_d = en ? seg : SEG_BLANK;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            anodes_q   <= ANODES_OFF;
            cathodes_q <= SEG_BLANK;
        end else begin
            cnt_q      <= cnt_d;
            anodes_q   <= anodes_d;
            cathodes_q <= cathodes_d;
        end
    end

    assign bus.anodes   = anodes_q;
    assign bus.cathodes = cathodes_q;

endmodule

// File: tb/tb_four_digit_seven_segment_decoder.sv
// Testbench for four_digit_seven_segment_decoder with a small refresh counter.
// Outputs are compared every cycle against a slot/time reference model.
module tb_four_digit_seven_segment_decoder;

    localparam int RB    = 6;
    localparam int SLOT  = 1 << (RB - 2);
    localparam int FRAME = 4 * SLOT;

    logic clk_100MHz = 1'b0;
    logic rst_n      = 1'b0;

    four_digit_seven_segment_decoder_if bus ();

    four_digit_seven_segment_decoder #(
        .REFRESH_BITS (RB)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int errs   = 0;
    int checks = 0;
    int t      = 0;

    logic [7:0] font [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [7:0] ref_seg(logic [3:0] v, logic dec);
        if (dec && v >= 4'd10) return 8'hFF;
        return font[v];
    endfunction

    // One clock; t is the counter value seen at this edge.
    task automatic step();
        logic [3:0] va [4];
        logic [3:0] dg;
        logic       dc;
        int         k;
        logic [3:0] ea;
        logic [7:0] ec;
        @(posedge clk_100MHz);
        va = '{bus.v0, bus.v1, bus.v2, bus.v3};
        dg = bus.digits;
        dc = bus.decimal;
        k  = (t / SLOT) % 4;
        t  = t + 1;
        #1;
        ea = 4'hF;
        ec = 8'hFF;
        if (dg[k]) begin
            ea[k] = 1'b0;
            ec    = ref_seg(va[k], dc);
        end
        chk("anodes", 32'(bus.anodes), 32'(ea));
        chk("cathodes", 32'(bus.cathodes), 32'(ec));
        chk("one_anode", 32'($countones(~bus.anodes) <= 1), 32'd1);
    endtask

    task automatic set_vals(logic [3:0] a3, logic [3:0] a2,
                            logic [3:0] a1, logic [3:0] a0);
        bus.v3 = a3;
        bus.v2 = a2;
        bus.v1 = a1;
        bus.v0 = a0;
    endtask

    initial begin
        set_vals(4'd4, 4'd3, 4'd2, 4'd1);
        bus.digits  = 4'b1111;
        bus.decimal = 1'b0;

        // Reset held
        repeat (10) begin
            @(negedge clk_100MHz);
            chk("rst_anodes", 32'(bus.anodes), 32'hF);
            chk("rst_cathodes", 32'(bus.cathodes), 32'hFF);
        end
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        t = 0;
        step();
        chk("first_anodes", 32'(bus.anodes), 32'hE);
        chk("first_cathodes", 32'(bus.cathodes), 32'hF9);

        // Full scan, two frames
        for (int i = 1; i < 2 * FRAME; i++) step();

        // Digit masking
        for (int m = 0; m < 3; m++) begin
            bus.digits = (m == 0) ? 4'b0001 : (m == 1) ? 4'b0011 : 4'b0111;
            for (int i = 0; i < FRAME; i++) step();
        end

        // Mode select over every value
        bus.digits = 4'b0001;
        for (int v = 0; v < 16; v++) begin
            for (int d = 0; d < 2; d++) begin
                bus.v0      = 4'(v);
                bus.decimal = 1'(d);
                for (int i = 0; i < 4; i++) step();
            end
        end

        // Latency: mid-slot 0 value change
        bus.digits  = 4'b1111;
        bus.decimal = 1'b0;
        bus.v0      = 4'd1;
        while ((t % FRAME) != 5) step();
        step();
        chk("lat_before", 32'(bus.cathodes), 32'hF9);
        bus.v0 = 4'd8;
        step();
        chk("lat_after", 32'(bus.cathodes), 32'h80);

        // Wrap: counter 63 -> slot 3, then 0 -> slot 0 one clock later
        while ((t % FRAME) != FRAME - 1) step();
        step();
        chk("wrap_last", 32'(bus.anodes), 32'h7);
        step();
        chk("wrap_first", 32'(bus.anodes), 32'hE);

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            set_vals(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            bus.digits  = 4'($urandom);
            bus.decimal = 1'($urandom);
            step();
        end

        // Reset asserted mid-slot blanks immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_anodes", 32'(bus.anodes), 32'hF);
        chk("midrst_cathodes", 32'(bus.cathodes), 32'hFF);
        repeat (3) begin
            @(negedge clk_100MHz);
            chk("midrst_hold", 32'(bus.cathodes), 32'hFF);
        end
        set_vals(4'd4, 4'd3, 4'd2, 4'd1);
        bus.digits = 4'b1111;
        @(negedge clk_100MHz);
        rst_n = 1'b1;
        t = 0;
        step();
        chk("restart_slot0", 32'(bus.anodes), 32'hE);
        for (int i = 1; i < FRAME; i++) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
